// File: rtl/move_engine_sequencer.sv
// ---------------------------------------------------------------------------
// move_engine_sequencer
//   Sequences the chess engine between an init phase, idle (READY), move
//   generation (GEN) and board update (UPD). Each op runs for a minimum number
//   of cycles and also waits for the engine's completion strobe and for the
//   host to release its request. An update request that collides with GEN is
//   queued and serviced as soon as GEN returns to READY.
//
// Optional feature (macro MES_TIMEOUT_EN):
//   defined   : an op that has not seen its done strobe by cnt ==
//               TIMEOUT_CYCLES-1 is aborted with a one-cycle op_err pulse.
//   undefined : no timeout; op_err is constant 0; ops wait indefinitely.
//
// Ports
//   clk           in  rising-edge clock
//   reset         in  asynchronous, active-high reset
//   gen           in  move-generation request (level)
//   update        in  board-update request (level)
//   gen_done      in  engine strobe: generation finished
//   upd_done      in  engine strobe: update finished
//   software_stop out high while GEN or UPD is active
//   init          out high during INIT
//   gen_busy      out high in GEN
//   upd_busy      out high in UPD
//   op_done       out 1-cycle pulse on normal op completion
//   op_is_upd     out qualifies op_done/op_err: 0=GEN, 1=UPD
//   op_err        out 1-cycle pulse on timeout abort
// ---------------------------------------------------------------------------
module move_engine_sequencer #(
  parameter int CNT_W          = 8,
  parameter int INIT_CYCLES    = 4,
  parameter int GEN_CYCLES     = 64,
  parameter int UPD_CYCLES     = 16,
  parameter int TIMEOUT_CYCLES = 200
) (
  input  logic clk,
  input  logic reset,
  input  logic gen,
  input  logic update,
  input  logic gen_done,
  input  logic upd_done,
  output logic software_stop,
  output logic init,
  output logic gen_busy,
  output logic upd_busy,
  output logic op_done,
  output logic op_is_upd,
  output logic op_err
);

  typedef enum logic [1:0] {S_INIT, S_READY, S_GEN, S_UPD} state_t;

  localparam logic [CNT_W-1:0] INIT_LAST = CNT_W'(INIT_CYCLES - 1);
  localparam logic [CNT_W-1:0] GEN_LAST  = CNT_W'(GEN_CYCLES - 1);
  localparam logic [CNT_W-1:0] UPD_LAST  = CNT_W'(UPD_CYCLES - 1);
  localparam logic [CNT_W-1:0] TO_LAST   = CNT_W'(TIMEOUT_CYCLES - 1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
  logic             done_seen_q, done_seen_d;
  logic             pend_q, pend_d;
  logic             op_done_q, op_done_d;
  logic             op_err_q, op_err_d;
  logic             op_is_upd_q, op_is_upd_d;
  logic             init_q, gen_busy_q, upd_busy_q, stop_q;
  logic             timeout_hit;

  // Op counter saturates rather than wrapping, so a long-held request can
  // never re-trigger the minimum-length or timeout comparisons.
  assign cnt_inc = (&cnt_q) ? cnt_q : cnt_q + 1'b1;

`ifdef MES_TIMEOUT_EN
  assign timeout_hit = ((state_q == S_GEN) || (state_q == S_UPD)) &&
                       (cnt_q == TO_LAST) && !done_seen_q;
`else
  // Timeout path compiled out: constant 0.
  assign timeout_hit = 1'b0 & (cnt_q == TO_LAST);
`endif

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    done_seen_d = done_seen_q;
    pend_d      = pend_q;
    op_done_d   = 1'b0;
    op_err_d    = 1'b0;
    op_is_upd_d = op_is_upd_q;
    case (state_q)
      S_INIT: begin
        // cnt doubles as the init-phase timer; requests are ignored here.
        cnt_d = cnt_q + 1'b1;
        if (cnt_q >= INIT_LAST) begin
          state_d = S_READY;
          cnt_d   = '0;
        end
      end
      S_READY: begin
        if (gen) begin
          state_d     = S_GEN;
          cnt_d       = '0;
          done_seen_d = 1'b0;
          if (update) pend_d = 1'b1;
        end else if (update || pend_q) begin
          state_d     = S_UPD;
          cnt_d       = '0;
          done_seen_d = 1'b0;
          pend_d      = 1'b0;
        end
      end
      S_GEN: begin
        cnt_d = cnt_inc;
        if (gen_done) done_seen_d = 1'b1;
        if (update)   pend_d      = 1'b1;
        // Timeout wins over a done strobe arriving in the same cycle.
        if (timeout_hit) begin
          state_d     = S_READY;
          op_err_d    = 1'b1;
          op_is_upd_d = 1'b0;
        end else if ((cnt_q >= GEN_LAST) && (done_seen_q || gen_done) && !gen) begin
          state_d     = S_READY;
          op_done_d   = 1'b1;
          op_is_upd_d = 1'b0;
        end
      end
      S_UPD: begin
        cnt_d = cnt_inc;
        if (upd_done) done_seen_d = 1'b1;
        if (timeout_hit) begin
          state_d     = S_READY;
          op_err_d    = 1'b1;
          op_is_upd_d = 1'b1;
        end else if ((cnt_q >= UPD_LAST) && (done_seen_q || upd_done) && !update) begin
          state_d     = S_READY;
          op_done_d   = 1'b1;
          op_is_upd_d = 1'b1;
        end
      end
      default: state_d = S_INIT;
    endcase
  end

  // Outputs are registered from the next state so they change together with
  // the state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_INIT;
      cnt_q       <= '0;
      done_seen_q <= 1'b0;
      pend_q      <= 1'b0;
      op_done_q   <= 1'b0;
      op_err_q    <= 1'b0;
      op_is_upd_q <= 1'b0;
      init_q      <= 1'b1;
      gen_busy_q  <= 1'b0;
      upd_busy_q  <= 1'b0;
      stop_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      done_seen_q <= done_seen_d;
      pend_q      <= pend_d;
      op_done_q   <= op_done_d;
      op_err_q    <= op_err_d;
      op_is_upd_q <= op_is_upd_d;
      init_q      <= (state_d == S_INIT);
      gen_busy_q  <= (state_d == S_GEN);
      upd_busy_q  <= (state_d == S_UPD);
      stop_q      <= (state_d == S_GEN) || (state_d == S_UPD);
    end
  end

  assign init          = init_q;
  assign gen_busy      = gen_busy_q;
  assign upd_busy      = upd_busy_q;
  assign software_stop = stop_q;
  assign op_done       = op_done_q;
  assign op_err        = op_err_q;
  assign op_is_upd     = op_is_upd_q;

endmodule

// File: tb/tb_move_engine_sequencer.sv
module tb_move_engine_sequencer;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic gen = 1'b0, update = 1'b0, gen_done = 1'b0, upd_done = 1'b0;
  logic software_stop, init, gen_busy, upd_busy, op_done, op_is_upd, op_err;

  int checks = 0;
  int errors = 0;
  int evt_cnt = 0;

  typedef struct packed {
    logic upd;
    logic err;
  } exp_t;

  exp_t sbq[$];
  exp_t mon_e;

  always #5 clk = ~clk;

  move_engine_sequencer #(
    .CNT_W(8), .INIT_CYCLES(4), .GEN_CYCLES(64), .UPD_CYCLES(16), .TIMEOUT_CYCLES(200)
  ) dut (
    .clk(clk), .reset(reset), .gen(gen), .update(update),
    .gen_done(gen_done), .upd_done(upd_done),
    .software_stop(software_stop), .init(init), .gen_busy(gen_busy),
    .upd_busy(upd_busy), .op_done(op_done), .op_is_upd(op_is_upd), .op_err(op_err)
  );

  // Scoreboard: every op_done/op_err event pops one expected entry.
  always @(negedge clk) begin
    if (!reset && (op_done || op_err)) begin
      evt_cnt++;
      checks++;
      if (sbq.size() == 0) begin
        errors++;
        $display("FAIL op_event_unexpected got done=%0b err=%0b is_upd=%0b want no event",
                 op_done, op_err, op_is_upd);
      end else begin
        mon_e = sbq.pop_front();
        if ({op_done, op_err, op_is_upd} !== {~mon_e.err, mon_e.err, mon_e.upd}) begin
          errors++;
          $display("FAIL op_event got done=%0b err=%0b is_upd=%0b want done=%0b err=%0b is_upd=%0b",
                   op_done, op_err, op_is_upd, ~mon_e.err, mon_e.err, mon_e.upd);
        end
      end
    end
  end

  // One-cycle request pulse; the DUT samples it at the second posedge.
  task automatic pulse_req(input logic g, input logic u);
    @(posedge clk); #1;
    gen = g; update = u;
    @(posedge clk); #1;
    gen = 1'b0; update = 1'b0;
  endtask

  // Counts busy cycles of one op, firing the matching strobe on busy cycle
  // done_at, the other op's strobe on cycle other_at, and dropping the request
  // on cycle drop_at. len = -1 if the op never ends within the bound.
  task automatic measure_busy(input bit upd, input int done_at, input int other_at,
                              input int drop_at, output int len);
    int k;
    bit b;
    k = 0;
    len = -1;
    for (int i = 0; i < 700; i++) begin
      @(negedge clk);
      b = upd ? upd_busy : gen_busy;
      if (b) begin
        k++;
        if (upd) begin upd_done = (k == done_at); gen_done = (k == other_at); end
        else     begin gen_done = (k == done_at); upd_done = (k == other_at); end
        if (drop_at != 0 && k == drop_at) begin
          if (upd) update = 1'b0; else gen = 1'b0;
        end
      end else if (k > 0) begin
        len = k;
        break;
      end
    end
    gen_done = 1'b0;
    upd_done = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    int n;
    bit busy_seen;
    #1 reset = 1'b1;
    @(negedge clk);
    checks++;
    if ({init, software_stop, gen_busy, upd_busy, op_done, op_is_upd, op_err} !== 7'b1000000) begin
      errors++;
      $display("FAIL reset_outputs got %b want 1000000",
               {init, software_stop, gen_busy, upd_busy, op_done, op_is_upd, op_err});
    end
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    update = 1'b1;  // request during INIT must be ignored
    n = 0;
    busy_seen = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (init) n++;
      if (upd_busy || gen_busy) busy_seen = 1'b1;
      if (i == 1) update = 1'b0;
    end
    checks++;
    if (n != 4) begin
      errors++;
      $display("FAIL init_length got %0d want 4", n);
    end
    checks++;
    if (init !== 1'b0) begin
      errors++;
      $display("FAIL init_low_after got %b want 0", init);
    end
    checks++;
    if (busy_seen) begin
      errors++;
      $display("FAIL init_request_ignored got busy=1 want 0");
    end
  endtask

  task automatic test_gen_single();
    int len, e0;
    e0 = evt_cnt;
    sbq.push_back('{upd: 1'b0, err: 1'b0});
    pulse_req(1'b1, 1'b0);
    measure_busy(1'b0, 11, 0, 0, len);
    checks++;
    if (len != 64) begin
      errors++;
      $display("FAIL gen_single_len got %0d want 64", len);
    end
    checks++;
    if (evt_cnt - e0 != 1) begin
      errors++;
      $display("FAIL gen_single_events got %0d want 1", evt_cnt - e0);
    end
  endtask

  task automatic test_collision();
    int len_g, len_u;
    bit busy_seen;
    sbq.push_back('{upd: 1'b0, err: 1'b0});
    sbq.push_back('{upd: 1'b1, err: 1'b0});
    pulse_req(1'b1, 1'b1);
    measure_busy(1'b0, 5, 0, 0, len_g);
    measure_busy(1'b1, 3, 0, 0, len_u);
    checks++;
    if (len_g != 64) begin
      errors++;
      $display("FAIL collision_gen_len got %0d want 64", len_g);
    end
    checks++;
    if (len_u != 16) begin
      errors++;
      $display("FAIL collision_upd_len got %0d want 16", len_u);
    end
    busy_seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (gen_busy || upd_busy || software_stop) busy_seen = 1'b1;
    end
    checks++;
    if (busy_seen) begin
      errors++;
      $display("FAIL collision_idle_after got busy=1 want 0");
    end
  endtask

  task automatic test_gen_held();
    int len, e0;
    e0 = evt_cnt;
    sbq.push_back('{upd: 1'b0, err: 1'b0});
    @(posedge clk); #1;
    gen = 1'b1;
    measure_busy(1'b0, 21, 0, 100, len);
    checks++;
    if (len != 100) begin
      errors++;
      $display("FAIL gen_held_len got %0d want 100", len);
    end
    checks++;
    if (evt_cnt - e0 != 1) begin
      errors++;
      $display("FAIL gen_held_events got %0d want 1", evt_cnt - e0);
    end
  endtask

  task automatic test_upd_strobe_select();
    int len;
    sbq.push_back('{upd: 1'b1, err: 1'b0});
    pulse_req(1'b0, 1'b1);
    measure_busy(1'b1, 30, 3, 0, len);
    checks++;
    if (len != 30) begin
      errors++;
      $display("FAIL upd_strobe_select_len got %0d want 30", len);
    end
  endtask

  task automatic test_reset_mid_op();
    int k, e0;
    bit busy_seen;
    pulse_req(1'b1, 1'b1);  // also queues an update
    k = 0;
    for (int i = 0; i < 100 && k < 31; i++) begin
      @(negedge clk);
      if (gen_busy) k++;
    end
    checks++;
    if (k != 31 || software_stop !== 1'b1) begin
      errors++;
      $display("FAIL midop_before_reset got cycles=%0d stop=%b want 31 1", k, software_stop);
    end
    e0 = evt_cnt;
    #2 reset = 1'b1;
    #1;
    checks++;
    if ({init, software_stop, gen_busy, upd_busy, op_done, op_is_upd, op_err} !== 7'b1000000) begin
      errors++;
      $display("FAIL midop_reset_outputs got %b want 1000000",
               {init, software_stop, gen_busy, upd_busy, op_done, op_is_upd, op_err});
    end
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    busy_seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (gen_busy || upd_busy) busy_seen = 1'b1;
    end
    checks++;
    if (busy_seen) begin
      errors++;
      $display("FAIL midop_pending_cleared got busy=1 want 0");
    end
    checks++;
    if (evt_cnt != e0) begin
      errors++;
      $display("FAIL midop_no_event got %0d want 0", evt_cnt - e0);
    end
  endtask

`ifdef MES_TIMEOUT_EN
  task automatic test_timeout();
    int len;
    sbq.push_back('{upd: 1'b1, err: 1'b1});
    pulse_req(1'b0, 1'b1);
    measure_busy(1'b1, 0, 0, 0, len);
    checks++;
    if (len != 200) begin
      errors++;
      $display("FAIL timeout_len got %0d want 200", len);
    end
  endtask
`else
  task automatic test_no_timeout();
    int len;
    sbq.push_back('{upd: 1'b1, err: 1'b0});
    pulse_req(1'b0, 1'b1);
    measure_busy(1'b1, 300, 0, 0, len);
    checks++;
    if (len != 300) begin
      errors++;
      $display("FAIL no_timeout_len got %0d want 300", len);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_gen_single();
    test_collision();
    test_gen_held();
    test_upd_strobe_select();
    test_reset_mid_op();
`ifdef MES_TIMEOUT_EN
    test_timeout();
`else
    test_no_timeout();
`endif
    repeat (3) @(negedge clk);
    checks++;
    if (sbq.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drained got %0d left want 0", sbq.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
